rev_counter_n: RTL and testbench

//  Parametrised multi-digit reversible counter for the 7-segment display path.
//  - Counts up or down in hex or BCD, one step per internal prescaler tick.
//  - No derived clock is used.
//  - Provides synchronous load, pause, a synchronised direction switch and a terminal-count pulse.
//  - The cnt output feeds the display driver's hex-digit input directly.

---
 rtl/rev_counter_pkg.sv | 17 +
 rtl/rev_counter_n_tick_prescaler.sv | 33 +++
 rtl/rev_counter_n.sv | 118 +++++++++++
 tb/tb_rev_counter_n.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rev_counter_pkg.sv
// rtl/rev_counter_pkg.sv - shared constants and width helper for the reversible counter
package rev_counter_pkg;

  localparam logic       DIR_UP   = 1'b0;
  localparam logic       DIR_DOWN = 1'b1;
  localparam logic [3:0] HEX_MAX  = 4'hF;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rev_counter_n_tick_prescaler.sv
// rtl/rev_counter_n_tick_prescaler.sv - enable-pulse generator, one pulse every TICK_DIV enabled cycles
module tick_prescaler
  import rev_counter_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] count;

  assign tick = en && (count == LAST);

  // Holding on en=0 keeps the partially elapsed period instead of restarting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/rev_counter_n.sv
// rtl/rev_counter_n.sv - multi-digit hex/BCD up/down counter with load, pause and terminal-count pulse
module rev_counter_n
  import rev_counter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BCD         = 0,
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] cnt,
  output logic                tc,
  output logic                dir_led,
  output logic                tick
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] DMAX = (BCD != 0) ? BCD_MAX : HEX_MAX;

  logic [SYNC_STAGES-1:0] dir_sync;
  logic                   step;
  logic                   down;
  logic [DIGITS:0]        ripple;
  logic [W-1:0]           next_cnt;
  logic [W-1:0]           load_clamped;
  logic [W-1:0]           cnt_q;
  logic                   tick_q;
  logic                   tc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_sync <= '0;
    end else begin
      dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir};
    end
  end

  assign dir_led = dir_sync[SYNC_STAGES-1];
  assign down    = (dir_led != DIR_UP);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (step)
  );

  // ripple[i] is the carry (up) or borrow (down) entering digit i; digit 0 always steps.
  assign ripple[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] nxt;
    logic [3:0] raw;
    logic       co;

    assign cur = cnt_q[4*i +: 4];
    assign raw = load_val[4*i +: 4];

    always_comb begin
      nxt = cur;
      co  = 1'b0;
      if (ripple[i]) begin
        if (down) begin
          if (cur == 4'd0) begin
            nxt = DMAX;
            co  = 1'b1;
          end else begin
            nxt = cur - 4'd1;
          end
        end else begin
          if (cur >= DMAX) begin
            nxt = 4'd0;
            co  = 1'b1;
          end else begin
            nxt = cur + 4'd1;
          end
        end
      end
    end

    assign ripple[i+1]          = co;
    assign next_cnt[4*i +: 4]   = nxt;
    assign load_clamped[4*i +: 4] = ((BCD != 0) && (raw > BCD_MAX)) ? BCD_MAX : raw;
  end

  // A carry/borrow out of the top digit is exactly the all-max <-> zero wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else if (load) begin
      cnt_q  <= load_clamped;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      tick_q <= step;
      tc_q   <= step && ripple[DIGITS];
      if (step) begin
        cnt_q <= next_cnt;
      end
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_rev_counter_n.sv
// tb/tb_rev_counter_n.sv - scoreboard bench for rev_counter_n in BCD and hex configurations
module tb_rev_counter_n;

  typedef struct {
    logic [15:0] cnt;
    logic        tc;
    int          gap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en_a, dir_a, load_a;
  logic [7:0]  load_val_a, cnt_a;
  logic        tc_a, dir_led_a, tick_a;
  logic        en_b, dir_b, load_b;
  logic [15:0] load_val_b, cnt_b;
  logic        tc_b, dir_led_b, tick_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_a = 0, ref_a = 0;
  int   cyc_b = 0, ref_b = 0;

  rev_counter_n #(.DIGITS(2), .BCD(1), .TICK_DIV(4), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .dir(dir_a), .load(load_a), .load_val(load_val_a),
    .cnt(cnt_a), .tc(tc_a), .dir_led(dir_led_a), .tick(tick_a)
  );

  rev_counter_n #(.DIGITS(4), .BCD(0), .TICK_DIV(4), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .dir(dir_b), .load(load_b), .load_val(load_val_b),
    .cnt(cnt_b), .tc(tc_b), .dir_led(dir_led_b), .tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void push_a(input logic [7:0] c, input logic t, input int g);
    exp_t e;
    e.cnt = {8'h00, c};
    e.tc  = t;
    e.gap = g;
    q_a.push_back(e);
  endfunction

  function automatic void push_b(input logic [15:0] c, input logic t, input int g);
    exp_t e;
    e.cnt = c;
    e.tc  = t;
    e.gap = g;
    q_b.push_back(e);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc_a++;
    if (!rst_n || load_a) ref_a = cyc_a;
    #1;
    if (rst_n) begin
      if (tick_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_spurious_tick: got cnt %0h with no expected step", cnt_a);
        end else begin
          e = q_a.pop_front();
          chk("a_cnt", {24'd0, cnt_a}, {16'd0, e.cnt});
          chk("a_tc", {31'd0, tc_a}, {31'd0, e.tc});
          if (e.gap != 0) chk("a_gap", cyc_a - ref_a, e.gap);
        end
        ref_a = cyc_a;
      end else begin
        chk("a_tc_idle", {31'd0, tc_a}, 32'd0);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    cyc_b++;
    if (!rst_n || load_b) ref_b = cyc_b;
    #1;
    if (rst_n) begin
      if (tick_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_spurious_tick: got cnt %0h with no expected step", cnt_b);
        end else begin
          e = q_b.pop_front();
          chk("b_cnt", {16'd0, cnt_b}, {16'd0, e.cnt});
          chk("b_tc", {31'd0, tc_b}, {31'd0, e.tc});
          if (e.gap != 0) chk("b_gap", cyc_b - ref_b, e.gap);
        end
        ref_b = cyc_b;
      end else begin
        chk("b_tc_idle", {31'd0, tc_b}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; load_val_a = '0;
    en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; load_val_b = '0;
    cyc(3);
    chk("reset_cnt", {24'd0, cnt_a}, 32'd0);
    chk("reset_tc", {31'd0, tc_a}, 32'd0);
    chk("reset_tick", {31'd0, tick_a}, 32'd0);
    chk("reset_dir_led", {31'd0, dir_led_a}, 32'd0);

    // Count up from reset, then wrap 99 -> 00.
    push_a(8'h01, 1'b0, 4);
    push_a(8'h02, 1'b0, 4);
    push_a(8'h03, 1'b0, 4);
    rst_n = 1'b1;
    en_a  = 1'b1;
    cyc(12);
    load_a = 1'b1; load_val_a = 8'h97;
    push_a(8'h98, 1'b0, 4);
    push_a(8'h99, 1'b0, 4);
    push_a(8'h00, 1'b1, 4);
    push_a(8'h01, 1'b0, 4);
    cyc(1);
    load_a = 1'b0;
    chk("load_97", {24'd0, cnt_a}, 32'h97);
    cyc(16);

    // Direction switch and underflow 00 -> 99.
    load_a = 1'b1; load_val_a = 8'h00; dir_a = 1'b1;
    push_a(8'h99, 1'b1, 4);
    push_a(8'h98, 1'b0, 4);
    cyc(1);
    load_a = 1'b0;
    chk("load_00", {24'd0, cnt_a}, 32'h00);
    chk("dir_led_1clk", {31'd0, dir_led_a}, 32'd0);
    cyc(1);
    chk("dir_led_2clk", {31'd0, dir_led_a}, 32'd1);
    cyc(7);

    // Load coincident with a step edge wins.
    dir_a = 1'b0;
    cyc(3);
    load_a = 1'b1; load_val_a = 8'h42;
    cyc(1);
    load_a = 1'b0;
    chk("load_over_step_cnt", {24'd0, cnt_a}, 32'h42);
    chk("load_over_step_tick", {31'd0, tick_a}, 32'd0);
    push_a(8'h43, 1'b0, 4);
    push_a(8'h44, 1'b0, 14);

    // Pause mid-period.
    cyc(6);
    en_a = 1'b0;
    cyc(10);
    chk("pause_hold", {24'd0, cnt_a}, 32'h43);
    en_a = 1'b1;
    cyc(2);

    // Asynchronous reset between edges, then BCD clamping on load.
    rst_n = 1'b0;
    en_a  = 1'b0;
    #1;
    chk("async_rst_cnt", {24'd0, cnt_a}, 32'd0);
    chk("async_rst_tc", {31'd0, tc_a}, 32'd0);
    chk("async_rst_tick", {31'd0, tick_a}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    load_a = 1'b1; load_val_a = 8'hA5;
    cyc(1);
    chk("bcd_clamp_a5", {24'd0, cnt_a}, 32'h95);
    load_val_a = 8'h3F;
    cyc(1);
    chk("bcd_clamp_3f", {24'd0, cnt_a}, 32'h39);
    load_val_a = 8'hFB;
    cyc(1);
    load_a = 1'b0;
    chk("bcd_clamp_fb", {24'd0, cnt_a}, 32'h99);

    // Four hex digits: carry, borrow and full wrap both ways.
    cyc(1);
    load_b = 1'b1; load_val_b = 16'h00FF;
    push_b(16'h0100, 1'b0, 4);
    push_b(16'h00FF, 1'b0, 4);
    cyc(1);
    load_b = 1'b0;
    en_b   = 1'b1;
    chk("b_load_00ff", {16'd0, cnt_b}, 32'h00FF);
    cyc(4);
    dir_b = 1'b1;
    cyc(4);
    load_b = 1'b1; load_val_b = 16'hFFFF; dir_b = 1'b0;
    push_b(16'h0000, 1'b1, 4);
    push_b(16'hFFFF, 1'b1, 4);
    cyc(1);
    load_b = 1'b0;
    chk("b_load_ffff", {16'd0, cnt_b}, 32'hFFFF);
    cyc(4);
    dir_b = 1'b1;
    cyc(4);
    en_b = 1'b0;
    cyc(3);

    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
